// File: rtl/fp_mul_sched.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : fp_mul_sched                                               |
// | Description : Round-robin scheduler sharing one pipelined fp_mul between |
// |               NREQ requesters, with tag tracking, back-pressure stall    |
// |               via aclken and a drain/idle handshake. Optional per-       |
// |               requester grant counters under FP_MUL_SCHED_STAT_EN.       |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module fp_mul_sched #(
    parameter int NREQ    = 4,
    parameter int MUL_LAT = 8,
    parameter int TAG_W   = $clog2(NREQ)
`ifdef FP_MUL_SCHED_STAT_EN
    ,parameter int CNT_W  = 16
`endif
) (
    input  logic                 sys_clk_1,
    input  logic                 sys_rst_n,
    input  logic [NREQ-1:0]      req_valid,
    output logic [NREQ-1:0]      req_ready,
    input  logic [NREQ*32-1:0]   req_a,
    input  logic [NREQ*32-1:0]   req_b,
    output logic                 mul_aclken,
    output logic [31:0]          mul_a,
    output logic [31:0]          mul_b,
    input  logic [31:0]          mul_result,
    output logic                 res_valid,
    input  logic                 res_ready,
    output logic [31:0]          res_data,
    output logic [TAG_W-1:0]     res_tag,
    input  logic                 drain,
    output logic                 idle
`ifdef FP_MUL_SCHED_STAT_EN
    ,output logic [NREQ*CNT_W-1:0] stat_grants
`endif
);

    localparam logic [1:0] c_ST_RUN   = 2'd0;
    localparam logic [1:0] c_ST_DRAIN = 2'd1;
    localparam logic [1:0] c_ST_DONE  = 2'd2;

    logic [1:0]         r_state;
    logic [TAG_W-1:0]   r_ptr;
    logic [MUL_LAT-1:0] r_vld_sr;
    logic [TAG_W-1:0]   r_tag_sr [MUL_LAT];

    logic               w_aclken;
    logic               w_any;
    logic [TAG_W-1:0]   w_winner;
    logic               w_grant;

    function automatic logic [TAG_W-1:0] f_rr_idx(input logic [TAG_W-1:0] ptr, input int k);
        return TAG_W'((int'(ptr) + k) % NREQ);
    endfunction

    // Only a product stuck at the head with no consumer freezes the multiplier.
    assign w_aclken = ~(r_vld_sr[MUL_LAT-1] & ~res_ready);

    // Scan from the farthest offset down so the nearest requester after ptr wins.
    always_comb begin
        w_any    = 1'b0;
        w_winner = '0;
        for (int k = NREQ; k >= 1; k--) begin
            if (req_valid[f_rr_idx(r_ptr, k)]) begin
                w_any    = 1'b1;
                w_winner = f_rr_idx(r_ptr, k);
            end
        end
    end

    assign w_grant = (r_state == c_ST_RUN) && w_aclken && !drain && w_any;

    always_comb begin
        req_ready = '0;
        mul_a     = '0;
        mul_b     = '0;
        if (w_grant) begin
            req_ready[w_winner] = 1'b1;
            mul_a = req_a[32*w_winner +: 32];
            mul_b = req_b[32*w_winner +: 32];
        end
    end

    always_ff @(posedge sys_clk_1 or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            r_vld_sr <= '0;
            for (int i = 0; i < MUL_LAT; i++) r_tag_sr[i] <= '0;
            r_ptr    <= TAG_W'(NREQ - 1);
            r_state  <= c_ST_RUN;
        end else begin
            if (w_aclken) begin
                r_vld_sr[0] <= w_grant;
                r_tag_sr[0] <= w_grant ? w_winner : '0;
                for (int i = 1; i < MUL_LAT; i++) begin
                    r_vld_sr[i] <= r_vld_sr[i-1];
                    r_tag_sr[i] <= r_tag_sr[i-1];
                end
            end
            if (w_grant) r_ptr <= w_winner;
            case (r_state)
                c_ST_RUN:   if (drain)           r_state <= c_ST_DRAIN;
                c_ST_DRAIN: if (r_vld_sr == '0)  r_state <= c_ST_DONE;
                c_ST_DONE:  if (!drain)          r_state <= c_ST_RUN;
                default:                         r_state <= c_ST_RUN;
            endcase
        end
    end

    assign mul_aclken = w_aclken;
    assign res_valid  = r_vld_sr[MUL_LAT-1];
    assign res_tag    = r_tag_sr[MUL_LAT-1];
    assign res_data   = mul_result;
    assign idle       = (r_state == c_ST_DONE);

`ifdef FP_MUL_SCHED_STAT_EN
    for (genvar gi = 0; gi < NREQ; gi++) begin : g_stat
        logic [CNT_W-1:0] r_cnt;
        always_ff @(posedge sys_clk_1 or negedge sys_rst_n) begin
            if (!sys_rst_n) begin
                r_cnt <= '0;
            end else if (w_grant && (w_winner == TAG_W'(gi)) && (r_cnt != {CNT_W{1'b1}})) begin
                r_cnt <= r_cnt + CNT_W'(1);
            end
        end
        assign stat_grants[CNT_W*gi +: CNT_W] = r_cnt;
    end
`endif

endmodule
`default_nettype wire
